// File: rtl/fighter_anim_seq_pkg.sv
// Shared animation codes, sequencer states and strike types for the fighter animation sequencer.
package fighter_anim_pkg;

  localparam logic [3:0] ANIM_IDLE       = 4'd0;
  localparam logic [3:0] ANIM_WALK       = 4'd1;
  localparam logic [3:0] ANIM_HIT        = 4'd2;
  localparam logic [3:0] ANIM_JUMP       = 4'd3;
  localparam logic [3:0] ANIM_PUNCH_LOW  = 4'd4;
  localparam logic [3:0] ANIM_PUNCH_MID  = 4'd5;
  localparam logic [3:0] ANIM_KICK_HIGH  = 4'd6;
  localparam logic [3:0] ANIM_CROUCH     = 4'd7;
  localparam logic [3:0] ANIM_BLOCK_LOW  = 4'd8;
  localparam logic [3:0] ANIM_BLOCK_HIGH = 4'd9;

  localparam logic [1:0] STRIKE_NONE = 2'd0;
  localparam logic [1:0] STRIKE_LOW  = 2'd1;
  localparam logic [1:0] STRIKE_MID  = 2'd2;
  localparam logic [1:0] STRIKE_HIGH = 2'd3;

  typedef enum logic [1:0] {
    ST_LOOP    = 2'd0,
    ST_ONESHOT = 2'd1,
    ST_HOLD    = 2'd2
  } anim_state_e;

  function automatic anim_state_e anim_class(input logic [3:0] code);
    anim_state_e cls;
    case (code)
      ANIM_IDLE, ANIM_WALK:                         cls = ST_LOOP;
      ANIM_CROUCH, ANIM_BLOCK_LOW, ANIM_BLOCK_HIGH: cls = ST_HOLD;
      default:                                      cls = ST_ONESHOT;
    endcase
    return cls;
  endfunction

  function automatic logic [1:0] strike_of(input logic [3:0] code);
    logic [1:0] st;
    case (code)
      ANIM_PUNCH_LOW: st = STRIKE_LOW;
      ANIM_PUNCH_MID: st = STRIKE_MID;
      ANIM_KICK_HIGH: st = STRIKE_HIGH;
      default:        st = STRIKE_NONE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/fighter_anim_seq_if.sv
// Request/selection bundle between player control and the animation sequencer.
interface fighter_anim_seq_if;
  logic       frame_tick;
  logic       req_walk;
  logic       req_jump;
  logic       req_crouch;
  logic       req_block;
  logic       req_punch_low;
  logic       req_punch_mid;
  logic       req_kick_high;
  logic       hit;
  logic [3:0] selanim;
  logic [1:0] selframe;
  logic       busy;
  logic       strike;
  logic [1:0] strike_type;

  modport master (
    output frame_tick, req_walk, req_jump, req_crouch, req_block,
           req_punch_low, req_punch_mid, req_kick_high, hit,
    input  selanim, selframe, busy, strike, strike_type
  );

  modport slave (
    input  frame_tick, req_walk, req_jump, req_crouch, req_block,
           req_punch_low, req_punch_mid, req_kick_high, hit,
    output selanim, selframe, busy, strike, strike_type
  );
endinterface

// File: rtl/fighter_anim_seq_tick_div.sv
// Frame-tick divider: counts frame_tick pulses and flags the one that ends an animation frame.
module anim_tick_div #(
  parameter int TICKS_PER_FRAME = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_tick_i,
  input  logic clear_i,
  output logic advance_o
);

  localparam logic [3:0] TC = 4'(TICKS_PER_FRAME - 1);

  logic [3:0] cnt_q, cnt_d;

  assign advance_o = frame_tick_i && (cnt_q == TC);

  // Clear wins over a coincident tick so a restarted animation begins a full frame.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || advance_o) begin
      cnt_d = '0;
    end else if (frame_tick_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fighter_anim_seq.sv
// Fighter animation sequencer: maps player requests to sprite anim/frame selection.
// Build option ANIM_HIT_INTERRUPT_EN: when defined, hit restarts any one-shot immediately.
//
// state      | meaning
// ST_LOOP    | idle/walk, frames 0..3 repeating
// ST_ONESHOT | hit/jump/attacks, frames 0..3 once, then reselect
// ST_HOLD    | crouch/block, frame 0 while request held
module fighter_anim_seq
  import fighter_anim_pkg::*;
#(
  parameter int TICKS_PER_FRAME = 6
) (
  input logic               clock,
  input logic               reset,
  fighter_anim_seq_if.slave anim_if
);

  anim_state_e state_q, state_d;
  logic [3:0]  selanim_q, selanim_d;
  logic [1:0]  selframe_q, selframe_d;
  logic        busy_q, busy_d;
  logic        strike_q, strike_d;
  logic [1:0]  strike_type_q, strike_type_d;
`ifndef ANIM_HIT_INTERRUPT_EN
  logic        hit_pend_q, hit_pend_d;
`endif

  logic       advance;
  logic       tick_clear;
  logic       start;
  logic [3:0] start_code;
  logic [3:0] sel;

  anim_tick_div #(.TICKS_PER_FRAME(TICKS_PER_FRAME)) u_tick_div (
    .clock        (clock),
    .reset        (reset),
    .frame_tick_i (anim_if.frame_tick),
    .clear_i      (tick_clear),
    .advance_o    (advance)
  );

  always_comb begin
    sel = ANIM_IDLE;
    if (anim_if.hit) begin
      sel = ANIM_HIT;
    end else if (anim_if.req_kick_high) begin
      sel = ANIM_KICK_HIGH;
    end else if (anim_if.req_punch_mid) begin
      sel = ANIM_PUNCH_MID;
    end else if (anim_if.req_punch_low && anim_if.req_crouch) begin
      sel = ANIM_PUNCH_LOW;
    end else if (anim_if.req_jump) begin
      sel = ANIM_JUMP;
    end else if (anim_if.req_block) begin
      sel = anim_if.req_crouch ? ANIM_BLOCK_LOW : ANIM_BLOCK_HIGH;
    end else if (anim_if.req_crouch) begin
      sel = ANIM_CROUCH;
    end else if (anim_if.req_walk) begin
      sel = ANIM_WALK;
    end
  end

  always_comb begin
    state_d       = state_q;
    selanim_d     = selanim_q;
    selframe_d    = selframe_q;
    busy_d        = busy_q;
    strike_d      = 1'b0;
    strike_type_d = STRIKE_NONE;
    tick_clear    = 1'b0;
    start         = 1'b0;
    start_code    = sel;
`ifndef ANIM_HIT_INTERRUPT_EN
    hit_pend_d    = hit_pend_q;
`endif

    case (state_q)
      ST_ONESHOT: begin
`ifdef ANIM_HIT_INTERRUPT_EN
        if (anim_if.hit) begin
          start      = 1'b1;
          start_code = ANIM_HIT;
        end else
`else
        if (anim_if.hit && (selanim_q != ANIM_HIT)) begin
          hit_pend_d = 1'b1;
        end
`endif
        if (advance) begin
          if (selframe_q == 2'd3) begin
            start = 1'b1;
`ifndef ANIM_HIT_INTERRUPT_EN
            // A hit queued during the one-shot outranks whatever is requested now.
            start_code = hit_pend_q ? ANIM_HIT : sel;
            hit_pend_d = 1'b0;
`endif
          end else begin
            selframe_d = selframe_q + 2'd1;
            if (selframe_q == 2'd1) begin
              strike_type_d = strike_of(selanim_q);
              strike_d      = (strike_type_d != STRIKE_NONE);
            end
          end
        end
      end
      default: begin
        if (sel != selanim_q) begin
          start = 1'b1;
        end else if ((state_q == ST_LOOP) && advance) begin
          selframe_d = selframe_q + 2'd1;
        end
      end
    endcase

    if (start) begin
      selanim_d     = start_code;
      selframe_d    = 2'd0;
      tick_clear    = 1'b1;
      state_d       = anim_class(start_code);
      busy_d        = (anim_class(start_code) == ST_ONESHOT);
      strike_d      = 1'b0;
      strike_type_d = STRIKE_NONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_LOOP;
      selanim_q     <= ANIM_IDLE;
      selframe_q    <= 2'd0;
      busy_q        <= 1'b0;
      strike_q      <= 1'b0;
      strike_type_q <= STRIKE_NONE;
`ifndef ANIM_HIT_INTERRUPT_EN
      hit_pend_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      selanim_q     <= selanim_d;
      selframe_q    <= selframe_d;
      busy_q        <= busy_d;
      strike_q      <= strike_d;
      strike_type_q <= strike_type_d;
`ifndef ANIM_HIT_INTERRUPT_EN
      hit_pend_q    <= hit_pend_d;
`endif
    end
  end

  assign anim_if.selanim     = selanim_q;
  assign anim_if.selframe    = selframe_q;
  assign anim_if.busy        = busy_q;
  assign anim_if.strike      = strike_q;
  assign anim_if.strike_type = strike_type_q;

endmodule
